serial_frame_deserializer: RTL and testbench
============================================

# serial_frame_deserializer

Receive-side companion to the team's serial shift-register transmit path. Accepts a bit-serial, MSB-first stream qualified by `bit_valid` and hunts for a sync word by sliding a left-shifting window. It then deserializes a fixed-width data word, checks an even-parity bit, and presents the word on a one-entry valid/ready output buffer. It sits between the serial link and any parallel consumer.

## Interface
- `DATA_W`, default 8: data word width in bits (≥ 2).
- `SYNC_W`, default 4: sync word width in bits (≥ 2).
- `SYNC_PATTERN`, default 4'b1011: sync word, compared MSB-first, `SYNC_W` bits wide.

- `clk`, input, 1: clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `bit_valid`, input, 1: `serial_in` carries a valid bit this cycle.
- `serial_in`, input, 1: serial data bit.
- `data_out`, output, `DATA_W`: received word. Stable while `data_valid` is 1.
- `data_valid`, output, 1: output buffer holds an unread word.
- `data_ready`, input, 1: consumer accepts the word. Transfer occurs when `data_valid` and `data_ready` are both 1.
- `parity_err`, output, 1: one-cycle pulse; the frame failed parity and was dropped.
- `overrun`, output, 1: one-cycle pulse; a good frame was dropped because the buffer was full.
- `busy`, output, 1: 1 when the state is not HUNT.

## Operation
- Frame on the wire, MSB-first: `SYNC_W` sync bits, then `DATA_W` data bits, then 1 parity bit. The parity bit makes the total count of 1s in data plus parity even.
- Cycles with `bit_valid` = 0 change no shift, count or state register. Output handshake and pulse logic still operate in those cycles.
- **HUNT**:
  - On each valid bit, `sync_sr <= {sync_sr[SYNC_W-2:0], serial_in}`. The hunt counter saturates at `SYNC_W`.
  - A match occurs when the updated window value equals `SYNC_PATTERN` and at least `SYNC_W` bits have been received since entering HUNT. This prevents false matches on the cleared window.
  - On a match, go to DATA with the bit counter at 0.
  - Matching slides bit-by-bit, so no bits are lost on a partial match.
- **DATA**:
  - On each valid bit, `data_sr <= {data_sr[DATA_W-2:0], serial_in}` and the counter increments.
  - After the `DATA_W`-th bit, go to PARITY.
- **PARITY**, on the valid bit:
  - Compute `ok` = (XOR of `data_sr` and `serial_in`) == 0.
  - Always return to HUNT, clearing `sync_sr` and the hunt counter.
  - If not `ok`: pulse `parity_err` and discard the frame.
  - If `ok` and the buffer is free, or is being read in this same cycle (`data_valid` && `data_ready`): load `data_out` <= `data_sr` and keep or assert `data_valid`.
  - If `ok` and the buffer is full and not being read: pulse `overrun`, discard the new word, and leave `data_out` unchanged.
- Parity is not checked until the parity bit arrives. Sync is never searched inside DATA or PARITY.
- The buffer clears (`data_valid` <= 0) on a transfer, unless a new word loads in the same cycle.

## Timing
- Reset values:
  - `data_out` = 0, `data_valid` = 0, `parity_err` = 0, `overrun` = 0, `busy` = 0.
  - State = HUNT; `sync_sr`, `data_sr`, the hunt counter and the bit counter are all 0.
- Reset asserted mid-frame aborts the frame and forces the reset values immediately.
- A pending word in the buffer is lost on reset.
- `busy` goes to 1 on the clock edge that samples the last sync bit. It goes to 0 on the edge that samples the parity bit.
- Latency: `data_valid`, `parity_err` and `overrun` are registered. They take effect on the edge that samples the parity bit and are visible in the following cycle.
- `parity_err` and `overrun` are single-cycle pulses, mutually exclusive, and never asserted in the same cycle.
- Back-to-back frames are supported: the next frame's sync bits may start on the very next valid bit after parity.
- Minimum frame period is `SYNC_W` + `DATA_W` + 1 valid bits.

## Test plan
- **Basic frame**: parameters at defaults, `data_ready` = 1, send bits 1011 10100101 0 continuously. Required: `data_out` = 0xA5 and `data_valid` = 1 one cycle after the parity bit. `data_valid` = 0 in the next cycle, and `parity_err` = `overrun` = 0 throughout.
- **Parity error**: send the same frame with parity bit 1. Required: one-cycle `parity_err` pulse, `data_valid` stays 0, `busy` = 0 afterwards.
- **Overrun and simultaneous read**:
  - Hold `data_ready` = 0 and send frames 0x3C then 0xC3. Required: `overrun` pulses once, and `data_out` stays 0x3C with `data_valid` = 1.
  - Then raise `data_ready` exactly on the cycle the parity bit of a third frame, 0x81, is sampled. Required: 0x3C transfers, 0x81 loads, `data_valid` stays 1, and no overrun.
- **Sliding sync**: send 0 1 0 1 1 followed by data 0xFF with parity 0. Required: the match occurs on the 5th bit and `data_out` = 0xFF. Also, leading 0000 after reset must not match when `SYNC_PATTERN` = 4'b0000 until 4 bits have been received.
- **Gapped input**: send the basic frame with `bit_valid` = 0 on random cycles, about 50% duty. Required: same result as the basic frame, with `busy` held high through the gaps.
- **Reset mid-frame**: assert `rst` after 6 data bits. Required: all outputs 0 immediately. Then a clean frame of 0x5A is received correctly.

Source files
------------

// File: rtl/serial_frame_deserializer.sv
// Serial receive path: slides a window hunting for the sync word, deserializes an
// MSB-first data word, checks even parity and holds the word in a one-entry valid/ready buffer.
module serial_frame_deserializer #(
    parameter int                 DATA_W       = 8,
    parameter int                 SYNC_W       = 4,
    parameter logic [SYNC_W-1:0]  SYNC_PATTERN = 4'b1011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    // state  | meaning
    // HUNT   | sliding the sync window, waiting for SYNC_PATTERN
    // DATA   | shifting in DATA_W data bits
    // PARITY | next valid bit is parity; check, then load/drop and return to HUNT
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int HCW = $clog2(SYNC_W + 1);
    localparam int BCW = $clog2(DATA_W);
    localparam logic [HCW-1:0] HUNT_FULL = HCW'(SYNC_W);
    localparam logic [HCW-1:0] HUNT_ARM  = HCW'(SYNC_W - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [SYNC_W-1:0] sync_sr, sync_nxt, sync_shift;
    logic [DATA_W-1:0] data_sr, data_sr_nxt, data_out_nxt;
    logic [HCW-1:0]    hunt_cnt, hunt_nxt;
    logic [BCW-1:0]    bit_cnt, bit_nxt;
    logic              data_valid_nxt, parity_err_nxt, overrun_nxt;
    logic              xfer, parity_ok, load;

    assign sync_shift = {sync_sr[SYNC_W-2:0], serial_in};
    assign xfer       = data_valid && data_ready;
    assign parity_ok  = ~(^{data_sr, serial_in});
    assign busy       = (state != HUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            sync_sr    <= '0;
            data_sr    <= '0;
            hunt_cnt   <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sync_sr    <= sync_nxt;
            data_sr    <= data_sr_nxt;
            hunt_cnt   <= hunt_nxt;
            bit_cnt    <= bit_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            parity_err <= parity_err_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sync_nxt       = sync_sr;
        data_sr_nxt    = data_sr;
        hunt_nxt       = hunt_cnt;
        bit_nxt        = bit_cnt;
        data_out_nxt   = data_out;
        parity_err_nxt = 1'b0;
        overrun_nxt    = 1'b0;
        load           = 1'b0;

        if (bit_valid) begin
            case (state)
                HUNT: begin
                    sync_nxt = sync_shift;
                    if (hunt_cnt != HUNT_FULL) begin
                        hunt_nxt = hunt_cnt + HCW'(1);
                    end
                    // The armed check keeps the cleared window from matching an all-zero pattern.
                    if ((sync_shift == SYNC_PATTERN) && (hunt_cnt >= HUNT_ARM)) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end
                DATA: begin
                    data_sr_nxt = {data_sr[DATA_W-2:0], serial_in};
                    bit_nxt     = bit_cnt + BCW'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = PARITY;
                        bit_nxt   = '0;
                    end
                end
                PARITY: begin
                    state_nxt = HUNT;
                    sync_nxt  = '0;
                    hunt_nxt  = '0;
                    if (!parity_ok) begin
                        parity_err_nxt = 1'b1;
                    end else if (!data_valid || xfer) begin
                        load         = 1'b1;
                        data_out_nxt = data_sr;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end

        if (load) begin
            data_valid_nxt = 1'b1;
        end else if (xfer) begin
            data_valid_nxt = 1'b0;
        end else begin
            data_valid_nxt = data_valid;
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer: directed test-plan frames plus random frames,
// checked every cycle against a queue-based frame model.
module tb_serial_frame_deserializer;

    localparam int          DATA_W = 8;
    localparam int          SYNC_W = 4;
    localparam logic [3:0]  PAT    = 4'b1011;

    logic              clk;
    logic              rst;
    logic              bit_valid;
    logic              serial_in;
    logic              data_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              overrun;
    logic              busy;

    logic              z_valid;
    logic              z_in;
    logic [DATA_W-1:0] z_data_out;
    logic              z_data_valid;
    logic              z_parity_err;
    logic              z_overrun;
    logic              z_busy;

    int checks = 0;
    int errors = 0;

    serial_frame_deserializer #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PATTERN(PAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    serial_frame_deserializer #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PATTERN(4'b0000)) dut_z (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (z_valid),
        .serial_in  (z_in),
        .data_out   (z_data_out),
        .data_valid (z_data_valid),
        .data_ready (1'b1),
        .parity_err (z_parity_err),
        .overrun    (z_overrun),
        .busy       (z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bits since entering hunt, bits of the current frame, and the buffer.
    int          hunt_q[$];
    bit          frame_q[$];
    bit          m_in_frame = 1'b0;
    bit          m_valid    = 1'b0;
    bit          m_pe       = 1'b0;
    bit          m_ov       = 1'b0;
    int          m_data     = 0;

    task automatic model_reset();
        hunt_q.delete();
        frame_q.delete();
        m_in_frame = 1'b0;
        m_valid    = 1'b0;
        m_pe       = 1'b0;
        m_ov       = 1'b0;
        m_data     = 0;
    endtask

    function automatic bit window_matches();
        for (int i = 0; i < SYNC_W; i++) begin
            if (hunt_q[i] != ((int'(PAT) >> (SYNC_W - 1 - i)) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit xfer;
        bit load;
        int w;
        int ones;
        xfer = m_valid && data_ready;
        load = 1'b0;
        m_pe = 1'b0;
        m_ov = 1'b0;
        if (bit_valid) begin
            if (!m_in_frame) begin
                hunt_q.push_back(int'(serial_in));
                if (hunt_q.size() > SYNC_W) void'(hunt_q.pop_front());
                if (hunt_q.size() == SYNC_W && window_matches()) begin
                    m_in_frame = 1'b1;
                    frame_q.delete();
                end
            end else begin
                frame_q.push_back(serial_in);
                if (frame_q.size() == DATA_W + 1) begin
                    w = 0;
                    ones = int'(frame_q[DATA_W]);
                    for (int i = 0; i < DATA_W; i++) begin
                        w = w * 2 + int'(frame_q[i]);
                        ones += int'(frame_q[i]);
                    end
                    m_in_frame = 1'b0;
                    hunt_q.delete();
                    if (ones % 2 != 0) m_pe = 1'b1;
                    else if (!m_valid || xfer) begin
                        m_data  = w;
                        m_valid = 1'b1;
                        load    = 1'b1;
                    end else m_ov = 1'b1;
                end
            end
        end
        if (xfer && !load) m_valid = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("data_valid", 32'(data_valid), 32'(m_valid));
        chk("data_out",   32'(data_out),   32'(m_data));
        chk("parity_err", 32'(parity_err), 32'(m_pe));
        chk("overrun",    32'(overrun),    32'(m_ov));
        chk("busy",       32'(busy),       32'(m_in_frame));
    end

    task automatic drive(input logic v, input logic b, input logic r);
        @(posedge clk);
        #2;
        bit_valid  = v;
        serial_in  = b;
        data_ready = r;
    endtask

    // ready_mode: 0 low, 1 high, 2 random, 3 low except high with the parity bit
    task automatic send_frame(input logic [7:0] word, input bit bad_par, input int gap_pct,
                              input int ready_mode);
        logic [12:0] bits;
        logic        r;
        bits = {PAT, word, (^word) ^ bad_par};
        for (int i = 12; i >= 0; i--) begin
            r = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1)
                || (ready_mode == 3 && i == 0);
            while (int'($urandom_range(0, 99)) < gap_pct) drive(1'b0, 1'($urandom), r);
            drive(1'b1, bits[i], r);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bit_valid  = 1'b0;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        z_valid    = 1'b0;
        z_in       = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data_valid", 32'(data_valid), 0);
        chk("reset_data_out",   32'(data_out),   0);
        chk("reset_busy",       32'(busy),       0);
        rst = 1'b0;

        // all-zero pattern must not match until four bits have been seen
        @(posedge clk);
        #2;
        z_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("zero_pattern_hunt", 32'(z_busy), (k == 4) ? 1 : 0);
        end
        z_valid = 1'b0;

        // basic frame
        send_frame(8'hA5, 1'b0, 0, 1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("basic_valid", 32'(data_valid), 1);
        chk("basic_data",  32'(data_out),   32'hA5);
        @(negedge clk);
        chk("basic_valid_clear", 32'(data_valid), 0);

        // parity error
        send_frame(8'hA5, 1'b1, 0, 1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("perr_pulse", 32'(parity_err), 1);
        chk("perr_valid", 32'(data_valid), 0);
        chk("perr_busy",  32'(busy),       0);

        // overrun then simultaneous read and load
        send_frame(8'h3C, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_first_data", 32'(data_out), 32'h3C);
        send_frame(8'hC3, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_pulse", 32'(overrun),    1);
        chk("ovr_hold",  32'(data_out),   32'h3C);
        chk("ovr_valid", 32'(data_valid), 1);
        send_frame(8'h81, 1'b0, 0, 3);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("simul_data",  32'(data_out),   32'h81);
        chk("simul_valid", 32'(data_valid), 1);
        chk("simul_no_ovr", 32'(overrun),   0);
        repeat (2) drive(1'b0, 1'b0, 1'b1);

        // sliding sync: 0 1 0 1 1 matches on the fifth bit
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("slide_no_early", 32'(busy), 0);
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("slide_match", 32'(busy), 1);
        repeat (7) drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("slide_data", 32'(data_out), 32'hFF);
        chk("slide_valid", 32'(data_valid), 1);

        // gapped input
        send_frame(8'hA5, 1'b0, 50, 1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("gap_valid", 32'(data_valid), 1);
        chk("gap_data",  32'(data_out),   32'hA5);

        // reset after six data bits
        for (int i = 3; i >= 0; i--) drive(1'b1, PAT[i], 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        bit_valid = 1'b0;
        chk("pre_reset_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_busy",  32'(busy),       0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_data",  32'(data_out),   0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        send_frame(8'h5A, 1'b0, 0, 1);
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_data",  32'(data_out),   32'h5A);
        chk("post_rst_valid", 32'(data_valid), 1);

        // random frames with junk, gaps, random ready and occasional bad parity
        for (int f = 0; f < 60; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                drive(1'b1, 1'($urandom), 1'($urandom));
            send_frame(8'($urandom), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 40)), 2);
        end
        repeat (4) drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
